// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - CSR write-port bundle (write enable, address, data)
//
// Used twice by trap_sequencer: once for the pipeline's CSR write request
// and once for the single shared CSR write port toward the CSR unit.
//   we   : write enable
//   addr : 12-bit CSR address
//   data : 32-bit write data
// modport master drives the bundle, modport slave receives it.
interface trap_sequencer_if;
  logic        we;
  logic [11:0] addr;
  logic [31:0] data;

  modport master (output we, output addr, output data);
  modport slave  (input  we, input  addr, input  data);
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / MRET CSR update sequencer
//
// Serialises the CSR writes of a trap entry (mepc, mcause, [mtval], mstatus)
// or an MRET (mstatus) onto one shared CSR write port, stalls the pipeline
// while doing so, then issues a one-cycle fetch redirect.
//
// Optional feature macro: TRAP_SEQ_TVAL_EN adds the W_TVAL state and the
// latched tval register (trap path grows from 4 to 5 cycles).
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   trap_req_i        trap request (level); trap_pc_i/trap_cause_i/trap_tval_i
//   mret_i            MRET request (level)
//   mtvec_i, mepc_i, mstatus_i   current CSR values
//   pipe_csr_i        pipeline CSR write request (passed through when idle)
//   csr_o             shared CSR write port
//   stall_o           pipeline hold
//   redirect_o        one-cycle redirect pulse, redirect_pc_o its target
module trap_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  trap_sequencer_if.slave  pipe_csr_i,
  trap_sequencer_if.master csr_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
`ifdef TRAP_SEQ_TVAL_EN
    W_TVAL,
`endif
    W_STATUS,
    M_STATUS,
    REDIRECT
  } state_e;

  state_e      state_q, state_d;
  // pc_q holds the trapping PC for a trap, or the latched mepc for MRET.
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;
  logic [31:0] status_v;

`ifdef TRAP_SEQ_TVAL_EN
  logic [31:0] tval_q, tval_d;
  logic        unused_mtvec_lo;
  assign unused_mtvec_lo = ^mtvec_i[1:0];
`else
  logic        unused_inputs;
  assign unused_inputs = ^{trap_tval_i, mtvec_i[1:0]};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
`ifdef TRAP_SEQ_TVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
`ifdef TRAP_SEQ_TVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    mret_d        = mret_q;
`ifdef TRAP_SEQ_TVAL_EN
    tval_d        = tval_q;
`endif
    status_v      = mstatus_i;
    csr_o.we      = 1'b0;
    csr_o.addr    = '0;
    csr_o.data    = '0;
    stall_o       = 1'b1;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;

    case (state_q)
      IDLE: begin
        stall_o = trap_req_i | mret_i;
        if (trap_req_i) begin
          // Trap wins over a simultaneous MRET; the MRET is dropped.
          state_d = W_EPC;
          pc_d    = trap_pc_i;
          cause_d = trap_cause_i;
          mret_d  = 1'b0;
`ifdef TRAP_SEQ_TVAL_EN
          tval_d  = trap_tval_i;
`endif
        end else if (mret_i) begin
          state_d = M_STATUS;
          pc_d    = mepc_i;
          mret_d  = 1'b1;
        end else begin
          csr_o.we   = pipe_csr_i.we;
          csr_o.addr = pipe_csr_i.addr;
          csr_o.data = pipe_csr_i.data;
        end
      end
      W_EPC: begin
        csr_o.we   = 1'b1;
        csr_o.addr = 12'h341;
        csr_o.data = pc_q;
        state_d    = W_CAUSE;
      end
      W_CAUSE: begin
        csr_o.we   = 1'b1;
        csr_o.addr = 12'h342;
        csr_o.data = cause_q;
`ifdef TRAP_SEQ_TVAL_EN
        state_d    = W_TVAL;
`else
        state_d    = W_STATUS;
`endif
      end
`ifdef TRAP_SEQ_TVAL_EN
      W_TVAL: begin
        csr_o.we   = 1'b1;
        csr_o.addr = 12'h343;
        csr_o.data = tval_q;
        state_d    = W_STATUS;
      end
`endif
      W_STATUS: begin
        // MPIE <= MIE, MIE <= 0, MPP <= machine.
        status_v[7]     = mstatus_i[3];
        status_v[3]     = 1'b0;
        status_v[12:11] = 2'b11;
        csr_o.we        = 1'b1;
        csr_o.addr      = 12'h300;
        csr_o.data      = status_v;
        state_d         = REDIRECT;
      end
      M_STATUS: begin
        // MIE <= MPIE, MPIE <= 1.
        status_v[3] = mstatus_i[7];
        status_v[7] = 1'b1;
        csr_o.we    = 1'b1;
        csr_o.addr  = 12'h300;
        csr_o.data  = status_v;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mret_q ? pc_q : {mtvec_i[31:2], 2'b00};
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset quiesces every output in the same cycle, so a sequence
    // interrupted by reset never emits another write or a redirect.
    if (rst_i) begin
      csr_o.we      = 1'b0;
      csr_o.addr    = '0;
      csr_o.data    = '0;
      stall_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_tval = '0;
  logic        mret = 1'b0;
  logic [31:0] mtvec = '0;
  logic [31:0] mepc = '0;
  logic [31:0] mstatus = '0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  trap_sequencer_if pipe_if ();
  trap_sequencer_if csr_if ();

  trap_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .trap_req_i    (trap_req),
    .trap_pc_i     (trap_pc),
    .trap_cause_i  (trap_cause),
    .trap_tval_i   (trap_tval),
    .mret_i        (mret),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .mstatus_i     (mstatus),
    .pipe_csr_i    (pipe_if),
    .csr_o         (csr_if),
    .stall_o       (stall),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
  } ev_t;

  function automatic logic [31:0] trap_status(input logic [31:0] ms);
    return (ms & ~32'h0000_0088) | ((ms & 32'h8) << 4) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] ms);
    return (ms & ~32'h0000_0008) | ((ms & 32'h80) >> 4) | 32'h0000_0080;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // mode 0: no pipeline write, 1: fixed write 340<=55, 2: random
  task automatic drive_pipe(input int mode);
    if (mode == 0) begin
      pipe_if.we = 1'b0; pipe_if.addr = '0; pipe_if.data = '0;
    end else if (mode == 1) begin
      pipe_if.we = 1'b1; pipe_if.addr = 12'h340; pipe_if.data = 32'h55;
    end else begin
      pipe_if.we = 1'($urandom_range(0, 1));
      pipe_if.addr = 12'($urandom);
      pipe_if.data = $urandom;
    end
  endtask

  task automatic chk_out(input string tag, input ev_t e, input logic st);
    chk({tag, ".we"},    32'(csr_if.we),   32'(e.we));
    chk({tag, ".addr"},  32'(csr_if.addr), 32'(e.addr));
    chk({tag, ".data"},  csr_if.data,      e.data);
    chk({tag, ".stall"}, 32'(stall),       32'(st));
    chk({tag, ".redir"}, 32'(redirect),    32'(e.redir));
    chk({tag, ".rpc"},   redirect_pc,      e.rpc);
  endtask

  // One request (or none) presented in an IDLE cycle, followed by the
  // complete expected per-cycle response derived from the CSR rules.
  task automatic run_seq(input bit tr, input bit mr, input logic [31:0] pc,
                         input logic [31:0] cause, input logic [31:0] tval,
                         input logic [31:0] mepc_v, input logic [31:0] ms,
                         input logic [31:0] mtvec_v, input int noise,
                         input string tag);
    ev_t q[$];
    ev_t e;
    tick();
    trap_req = tr; mret = mr;
    trap_pc = pc; trap_cause = cause; trap_tval = tval;
    mepc = mepc_v; mstatus = ms; mtvec = mtvec_v;
    drive_pipe(noise);
    #1;
    if (tr || mr) begin
      e = '{we: 1'b0, addr: 12'h0, data: 32'h0, redir: 1'b0, rpc: 32'h0};
      chk_out({tag, ".accept"}, e, 1'b1);
    end else begin
      e = '{we: pipe_if.we, addr: pipe_if.addr, data: pipe_if.data, redir: 1'b0, rpc: 32'h0};
      chk_out({tag, ".pass"}, e, 1'b0);
    end
    if (tr) begin
      q.push_back('{we: 1'b1, addr: 12'h341, data: pc,    redir: 1'b0, rpc: 32'h0});
      q.push_back('{we: 1'b1, addr: 12'h342, data: cause, redir: 1'b0, rpc: 32'h0});
`ifdef TRAP_SEQ_TVAL_EN
      q.push_back('{we: 1'b1, addr: 12'h343, data: tval,  redir: 1'b0, rpc: 32'h0});
`endif
      q.push_back('{we: 1'b1, addr: 12'h300, data: trap_status(ms), redir: 1'b0, rpc: 32'h0});
      q.push_back('{we: 1'b0, addr: 12'h0, data: 32'h0, redir: 1'b1, rpc: mtvec_v & ~32'h3});
    end else if (mr) begin
      q.push_back('{we: 1'b1, addr: 12'h300, data: mret_status(ms), redir: 1'b0, rpc: 32'h0});
      q.push_back('{we: 1'b0, addr: 12'h0, data: 32'h0, redir: 1'b1, rpc: mepc_v});
    end
    foreach (q[i]) begin
      tick();
      if (noise == 2) begin
        trap_req = 1'($urandom_range(0, 1));
        mret = 1'($urandom_range(0, 1));
        trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
        mepc = $urandom;
      end
      drive_pipe(noise);
      #1;
      chk_out($sformatf("%s.c%0d", tag, i + 1), q[i], 1'b1);
    end
  endtask

  initial begin
    bit tr, mr;
    // Reset, with a pipeline write pending that must not leak through.
    drive_pipe(1);
    tick(); #1;
    chk("rst.we", 32'(csr_if.we), 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.redir", 32'(redirect), 32'h0);
    chk("rst.rpc", redirect_pc, 32'h0);
    tick();
    rst = 1'b0;
    drive_pipe(0);
    #1;
    chk("idle.we", 32'(csr_if.we), 32'h0);
    chk("idle.stall", 32'(stall), 32'h0);
    chk("idle.redir", 32'(redirect), 32'h0);

    // Directed cases; the trap runs with the 340<=55 write held throughout.
    run_seq(1, 0, 32'h100, 32'h2, 32'hDEAD, 32'h0, 32'h8, 32'h8001, 1, "trap");
    run_seq(0, 1, 32'h0, 32'h0, 32'h0, 32'h204, 32'h1880, 32'h8001, 1, "mret");
    run_seq(1, 1, 32'h400, 32'hB, 32'h1234, 32'h999, 32'h0, 32'h7000_0003, 0, "both");
    run_seq(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, "pass");

    // Reset while in W_CAUSE.
    tick();
    trap_req = 1'b1; trap_pc = 32'h300; trap_cause = 32'h5; mtvec = 32'h4000;
    drive_pipe(0);
    #1;
    chk("rstmid.accept", 32'(stall), 32'h1);
    tick();
    trap_req = 1'b0;
    #1;
    chk("rstmid.epc", 32'(csr_if.addr), 32'h341);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid.we", 32'(csr_if.we), 32'h0);
    chk("rstmid.redir", 32'(redirect), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid.idle_stall", 32'(stall), 32'h0);
    chk("rstmid.idle_we", 32'(csr_if.we), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("rstmid.no_redir", 32'(redirect), 32'h0);
      chk("rstmid.no_we", 32'(csr_if.we), 32'h0);
    end

    // Randomized back-to-back traffic with noise on ignored inputs.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      tr = (kind == 1) || (kind == 3);
      mr = (kind == 2) || (kind == 3);
      run_seq(tr, mr, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              2, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have no parameters; CSR addresses are fixed: mstatus 12'h300, mepc 12'h341, mcause 12'h342, mtval 12'h343.
REQ-002 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 trap_req_i  in  1  exception/interrupt request from pipeline, level.
REQ-005 trap_pc_i  in  32  PC of the trapping instruction.
REQ-006 trap_cause_i  in  32  mcause value.
REQ-007 trap_tval_i  in  32  mtval value; used only with TRAP_SEQ_TVAL_EN.
REQ-008 mret_i  in  1  MRET retire request, level.
REQ-009 mtvec_i, mepc_i, mstatus_i  in  32 each  current CSR values from the CSR unit.
REQ-010 pipe_csr_we_i  in  1; pipe_csr_addr_i  in  12; pipe_csr_data_i  in  32  pipeline CSR write request.
REQ-011 csr_we_o  out  1; csr_addr_o  out  12; csr_data_o  out  32  single shared CSR write port.
REQ-012 stall_o  out  1  pipeline hold.
REQ-013 redirect_o  out  1  one-cycle fetch redirect pulse; redirect_pc_o  out  32  target.

Function
REQ-014 States SHALL be IDLE, W_EPC, W_CAUSE, W_TVAL (macro only), W_STATUS, M_STATUS, REDIRECT.
REQ-015 In IDLE with trap_req_i=1, the block SHALL latch trap_pc_i, trap_cause_i and trap_tval_i, and go to W_EPC.
REQ-016 In IDLE with mret_i=1 and trap_req_i=0, the block SHALL latch mepc_i as the target and go to M_STATUS.
REQ-017 When trap_req_i and mret_i are both 1, the trap SHALL win and the MRET SHALL be dropped.
REQ-018 Trap path: W_EPC writes 0x341 <= latched pc; W_CAUSE writes 0x342 <= latched cause; [W_TVAL writes 0x343 <= latched tval]; W_STATUS; REDIRECT; then IDLE.
REQ-019 W_STATUS SHALL write 0x300 <= mstatus_i with bit7 (MPIE) <= bit3 (MIE), bit3 <= 0, bits[12:11] (MPP) <= 2'b11, and all other bits unchanged.
REQ-020 M_STATUS SHALL write 0x300 <= mstatus_i with bit3 <= bit7, bit7 <= 1, and all other bits unchanged, then go to REDIRECT.
REQ-021 REDIRECT SHALL pulse redirect_o for exactly 1 cycle; redirect_pc_o = {mtvec_i[31:2],2'b00} for a trap, or the latched mepc for MRET.
REQ-022 Timing relative to the acceptance cycle N: trap redirect occurs at N+4 (N+5 with the macro); MRET redirect occurs at N+2.
REQ-023 stall_o SHALL be 1 in every state other than IDLE, and SHALL also be 1 combinationally in IDLE whenever trap_req_i or mret_i is 1.
REQ-024 In IDLE with no request accepted, the csr_*_o outputs SHALL pass pipe_csr_*_i through combinationally.
REQ-025 When a request is accepted in IDLE, or in any non-IDLE state, pipeline CSR writes SHALL be blocked.
REQ-026 trap_req_i and mret_i SHALL be ignored outside IDLE.
REQ-027 The sequencer SHALL drive csr_we_o=1 only in W_* and M_STATUS states; in every other non-passthrough cycle it SHALL drive csr_we_o=0, csr_addr_o=0 and csr_data_o=0.
REQ-028 redirect_pc_o SHALL be 0 whenever redirect_o=0.
REQ-029 Back-to-back operation: a request present in the cycle after REDIRECT (the IDLE cycle) SHALL be accepted with no extra bubble.

Reset
REQ-030 With rst_i=1 at a clock edge, the state SHALL become IDLE and all latched values SHALL become 0.
REQ-031 During and after reset, the outputs SHALL hold csr_we_o=0, redirect_o=0, redirect_pc_o=0 and stall_o=0 (absent requests).
REQ-032 Reset mid-sequence SHALL abort the sequence with no further CSR writes and no redirect.

Configuration
REQ-033 Macro TRAP_SEQ_TVAL_EN: when defined, state W_TVAL exists between W_CAUSE and W_STATUS and trap_tval_i is latched.
REQ-034 When TRAP_SEQ_TVAL_EN is not defined, W_TVAL and the tval register SHALL be absent, trap_tval_i SHALL be unused, and the trap path SHALL be 4 cycles.

Verification
REQ-035 Trap: trap_pc_i=0x100, cause=0x2, mtvec_i=0x8001, mstatus_i=0x8 -> writes 341<=0x100, 342<=0x2, 300<=0x1880, then redirect_pc_o=0x8000 at N+4.
REQ-036 MRET: mepc_i=0x204, mstatus_i=0x1880 -> write 300<=0x1888, then redirect_o=1 with redirect_pc_o=0x204 at N+2.
REQ-037 Simultaneous trap_req_i=1 and mret_i=1 -> the trap sequence runs; no MRET status write occurs.
REQ-038 pipe_csr_we_i=1, addr=0x340, data=0x55 in IDLE with no request -> same-cycle write 340<=0x55; the same write during W_CAUSE -> blocked.
REQ-039 rst_i=1 in W_CAUSE -> next cycle IDLE, csr_we_o=0, and no redirect ever issued.
REQ-040 With TRAP_SEQ_TVAL_EN and tval=0xDEAD -> 343<=0xDEAD between the cause and status writes; redirect at N+5.
